// File: rtl/rx_frame_ctrl.sv
// Frame controller behind the UART byte receiver: SYNC/CMD/LEN/PAYLOAD/CSUM sequencing with XOR check.
// Strobes are registered one cycle after the byte event; an inter-byte timeout aborts a stalled frame.
module rx_frame_ctrl #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         MAX_LEN   = 16,
   parameter int         TIMEOUT   = 100000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_ready,
   output logic       o_busy,
   output logic [7:0] o_pl_data,
   output logic [7:0] o_pl_idx,
   output logic       o_pl_valid,
   output logic [7:0] o_cmd,
   output logic [7:0] o_len,
   output logic       o_frame_valid,
   output logic       o_err,
   output logic [1:0] o_err_code
);

   localparam int              TW        = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CSUM} state_t;

   state_t        state;
   logic          ready_q;
   logic [7:0]    csum;
   logic [7:0]    cnt;
   logic [TW-1:0] to_cnt;
   logic          evt;

   assign evt    = i_ready & ~ready_q;
   assign o_busy = (state != IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         ready_q       <= 1'b1;
         csum          <= '0;
         cnt           <= '0;
         to_cnt        <= '0;
         o_pl_data     <= '0;
         o_pl_idx      <= '0;
         o_pl_valid    <= 1'b0;
         o_cmd         <= '0;
         o_len         <= '0;
         o_frame_valid <= 1'b0;
         o_err         <= 1'b0;
         o_err_code    <= '0;
      end else begin
         ready_q       <= i_ready;
         o_pl_valid    <= 1'b0;
         o_frame_valid <= 1'b0;
         o_err         <= 1'b0;

         // A byte arriving on the expiry cycle takes priority over the timeout.
         if (evt) begin
            to_cnt <= '0;
            case (state)
               IDLE: begin
                  if (i_data == SYNC_BYTE)
                     state <= CMD;
               end
               CMD: begin
                  o_cmd <= i_data;
                  csum  <= i_data;
                  state <= LEN;
               end
               LEN: begin
                  if (i_data > MAX_LEN_B) begin
                     o_err      <= 1'b1;
                     o_err_code <= 2'd2;
                     state      <= IDLE;
                  end else begin
                     o_len <= i_data;
                     csum  <= csum ^ i_data;
                     cnt   <= '0;
                     state <= (i_data == 8'd0) ? CSUM : PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  o_pl_data  <= i_data;
                  o_pl_idx   <= cnt;
                  o_pl_valid <= 1'b1;
                  csum       <= csum ^ i_data;
                  cnt        <= cnt + 8'd1;
                  if (cnt == o_len - 8'd1)
                     state <= CSUM;
               end
               CSUM: begin
                  if (i_data == csum) begin
                     o_frame_valid <= 1'b1;
                  end else begin
                     o_err      <= 1'b1;
                     o_err_code <= 2'd1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state == IDLE) begin
            to_cnt <= '0;
         end else if (to_cnt == TO_LAST) begin
            o_err      <= 1'b1;
            o_err_code <= 2'd3;
            state      <= IDLE;
            to_cnt     <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule
